serv_wb_arbiter: RTL
====================

# serv_wb_arbiter

Two-master, one-slave Wishbone classic arbiter that shares the SERV memory bus target (the single-port program/data RAM) between the SERV CPU memory port and the SPI host bridge master, so firmware can be loaded and variables read over SPI while the core runs. It sits between `serv_wb_top`'s memory bus (`o_wb_mem_*` / `i_wb_mem_*`) and the RAM. Arbitration is round-robin with the grant held until the slave acknowledges. An optional watchdog terminates hung transfers.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in BUSY without a slave ack before forced termination. Used only when the timeout feature is compiled in. Legal range is 2..65535.
- `TIMEOUT_RDT`, default 32'hDEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- `i_clk`  in  1  clock. This is the only clock.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_m0_wb_adr` in 32, `i_m0_wb_dat` in 32, `i_m0_wb_sel` in 4, `i_m0_wb_we` in 1, `i_m0_wb_stb` in 1  master 0 (SERV CPU) request.
- `o_m0_wb_rdt`  out  32  master 0 read data.
- `o_m0_wb_ack`  out  1  master 0 ack.
- `i_m1_wb_*` / `o_m1_wb_*`  same set as master 0  master 1 (SPI host bridge).
- `o_s_wb_adr` out 32, `o_s_wb_dat` out 32, `o_s_wb_sel` out 4, `o_s_wb_we` out 1, `o_s_wb_stb` out 1, `o_s_wb_cyc` out 1  slave request.
- `i_s_wb_rdt`  in  32  slave read data.
- `i_s_wb_ack`  in  1  slave ack.
- `o_grant`  out  2  one-hot current owner. 00 means idle.
- `o_timeout`  out  1  one-cycle pulse when a transfer is force-terminated.

## Operation
- States are IDLE and BUSY. The `last` pointer records the most recent owner.
- **IDLE**
  - If exactly one `stb` is high, grant that master.
  - If both are high, grant the master not equal to `last`.
  - Then go to BUSY and set `last` to the new owner.
- **BUSY**
  - The slave outputs mirror the owner's adr/dat/sel/we. `o_s_wb_stb = o_s_wb_cyc = 1`.
  - `i_s_wb_ack` is forwarded combinationally to the owner's ack only. The other master's ack stays 0.
  - `i_s_wb_rdt` is broadcast to both `o_mX_wb_rdt`. Timeout termination is the one exception (see below).
  - On slave ack, go to IDLE next cycle and clear the grant.
  - If the owner drops `stb` before ack, this is an abort: go to IDLE next cycle, with no ack forwarded.
- In IDLE, all slave outputs are 0 and every `i_s_wb_ack` is ignored. This covers late acks after an abort, timeout or reset.
- **Fairness:** each transfer in both directions costs one IDLE cycle. When both masters request continuously, grants strictly alternate.
- **Reset values:** all outputs 0, state IDLE, `last` = m1, so m0 (CPU) wins the first contention. Timeout counter is 0.
- **Reset mid-BUSY:** on the next edge the state is IDLE, `o_s_wb_stb` is 0 and no ack is issued.

## Timing
- Request-to-slave-stb latency is 1 cycle: `stb` is seen in IDLE at edge N, and `o_s_wb_stb` is high after edge N.
- Ack path is combinational: slave ack at cycle K gives master ack at cycle K.
- Minimum transfer is 2 cycles (RAM with a registered 1-cycle ack). Back-to-back transfers by the same master run every 3 cycles.
- Grant and state are registered. The slave output muxes are driven from the registered grant, so there is no combinational stb-to-stb path.

## Configuration
- `SERV_WB_ARB_TIMEOUT_EN` defined:
  - A counter runs in BUSY and clears on entering BUSY.
  - When it reaches `TIMEOUT_CYCLES` without a slave ack, the owner gets a one-cycle ack with `o_mX_wb_rdt = TIMEOUT_RDT`.
  - `o_timeout` pulses in that same cycle, and the state goes to IDLE next cycle.
  - If a slave ack arrives in the same cycle as the terminal count, the slave ack wins: real rdt and no `o_timeout`.
- Not defined: no counter, `o_timeout` is tied 0, and BUSY waits indefinitely.

## Structure
- Package `serv_wb_arb_pkg` holds:
  - the state enum (IDLE, BUSY);
  - the grant encoding constants (`GNT_NONE`, `GNT_M0`, `GNT_M1`);
  - the default `TIMEOUT_RDT`.
- Sub-module `serv_wb_arb_timeout` is the watchdog counter, with clear, enable, terminal-count pulse and a `TIMEOUT_CYCLES` parameter. It is instantiated only under the macro.

## Test plan
- **Single master:** m0 reads 0x100, slave acks 1 cycle after stb with rdt 0x12345678 → `o_m0_wb_ack` pulses once, `o_m0_wb_rdt` = 0x12345678, `o_m1_wb_ack` = 0, `o_grant` sequence 00→01→00.
- **Contention after reset:** both request in the same cycle → m0 granted first, m1 granted in the IDLE cycle after m0's ack. With continuous requests, 6 transfers alternate 01,10,01,10,01,10.
- **Write pass-through:** m1 writes 0xCAFEF00D, sel 0011, adr 0x40 → slave sees exactly those values with we=1 throughout BUSY.
- **Abort:** m1 drops `stb` mid-BUSY, and the slave acks 2 cycles later → no ack to either master, and the arbiter is IDLE within 1 cycle.
- **Reset mid-BUSY:** `i_rst` is asserted while m0 is owner → all outputs are 0 after the edge, and a subsequent slave ack is ignored.
- **Timeout (macro on, `TIMEOUT_CYCLES`=8):** slave never acks → m0 gets ack with rdt 0xDEADBEEF and `o_timeout` pulses exactly 8 cycles into BUSY. A repeat run with the slave ack landing on cycle 8 gives the real rdt and no `o_timeout`.

Source files
------------

// File: rtl/serv_wb_arb_pkg.sv
// serv_wb_arb_pkg: shared types and constants for the SERV memory-bus arbiter.
// The optional watchdog is enabled with the SERV_WB_ARB_TIMEOUT_EN macro.
package serv_wb_arb_pkg;

  // Arbiter state: IDLE between transfers, BUSY while a master owns the slave.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // One-hot owner encoding, also driven out on o_grant.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Read data handed back when the watchdog terminates a hung transfer.
  localparam logic [31:0] TIMEOUT_RDT_DEFAULT = 32'hDEAD_BEEF;

  // One master's Wishbone request bundle, so the owner mux is a single select.
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
  } wb_req_t;

endpackage

// File: rtl/serv_wb_arb_timeout.sv
// serv_wb_arb_timeout: watchdog counter for the arbiter's BUSY state.
// Only instantiated when SERV_WB_ARB_TIMEOUT_EN is defined.
// o_tc is high in the TIMEOUT_CYCLES-th consecutive enabled cycle after a clear.
module serv_wb_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  // Count runs 0..TIMEOUT_CYCLES-1, so the terminal value lands on the Nth cycle.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign o_tc = i_en && (cnt_q == LAST_CNT);

  // Next count: clear wins, otherwise advance while enabled and not yet terminal.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && !o_tc) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignment so all registers update together at the edge.
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serv_wb_arbiter.sv
// serv_wb_arbiter: two-master, one-slave Wishbone classic round-robin arbiter
// sharing the SERV program/data RAM between the CPU (m0) and SPI bridge (m1).
// Define SERV_WB_ARB_TIMEOUT_EN to add a watchdog that terminates hung transfers.
module serv_wb_arbiter
  import serv_wb_arb_pkg::*;
#(
  parameter int unsigned  TIMEOUT_CYCLES = 255,
  parameter logic [31:0]  TIMEOUT_RDT    = TIMEOUT_RDT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // master 0: SERV CPU memory port
  input  logic [31:0] i_m0_wb_adr,
  input  logic [31:0] i_m0_wb_dat,
  input  logic [3:0]  i_m0_wb_sel,
  input  logic        i_m0_wb_we,
  input  logic        i_m0_wb_stb,
  output logic [31:0] o_m0_wb_rdt,
  output logic        o_m0_wb_ack,
  // master 1: SPI host bridge
  input  logic [31:0] i_m1_wb_adr,
  input  logic [31:0] i_m1_wb_dat,
  input  logic [3:0]  i_m1_wb_sel,
  input  logic        i_m1_wb_we,
  input  logic        i_m1_wb_stb,
  output logic [31:0] o_m1_wb_rdt,
  output logic        o_m1_wb_ack,
  // slave: shared RAM
  output logic [31:0] o_s_wb_adr,
  output logic [31:0] o_s_wb_dat,
  output logic [3:0]  o_s_wb_sel,
  output logic        o_s_wb_we,
  output logic        o_s_wb_stb,
  output logic        o_s_wb_cyc,
  input  logic [31:0] i_s_wb_rdt,
  input  logic        i_s_wb_ack,
  // status
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  // Reject illegal watchdog lengths at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("serv_wb_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;    // most recent owner: 0 = m0, 1 = m1

  wb_req_t     m0_req, m1_req, own_req;
  logic        busy;
  logic        slv_ack;           // slave ack accepted for the live owner
  logic        abort;             // owner withdrew stb before any ack
  logic        tmo_tc;            // watchdog terminal count this cycle
  logic        tmo_fire;          // transfer force-terminated this cycle
  logic        done;              // owner gets its ack this cycle
  logic [31:0] rdt_bus;

  assign m0_req = '{adr: i_m0_wb_adr, dat: i_m0_wb_dat, sel: i_m0_wb_sel,
                    we: i_m0_wb_we, stb: i_m0_wb_stb};
  assign m1_req = '{adr: i_m1_wb_adr, dat: i_m1_wb_dat, sel: i_m1_wb_sel,
                    we: i_m1_wb_we, stb: i_m1_wb_stb};

  assign busy = (state_q == ST_BUSY);

  // Owner request mux, selected by the registered grant (zero when idle).
  always_comb begin
    own_req = '0;
    case (grant_q)
      GNT_M0:  own_req = m0_req;
      GNT_M1:  own_req = m1_req;
      default: own_req = '0;
    endcase
  end

`ifdef SERV_WB_ARB_TIMEOUT_EN
  // Held clear while idle so every BUSY period counts from zero.
  serv_wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (!busy),
    .i_en  (busy),
    .o_tc  (tmo_tc)
  );
`else
  assign tmo_tc = 1'b0;
`endif

  // A real slave ack beats a coincident terminal count; an abort suppresses both.
  assign slv_ack  = busy && own_req.stb && i_s_wb_ack;
  assign abort    = busy && !own_req.stb;
  assign tmo_fire = busy && own_req.stb && !i_s_wb_ack && tmo_tc;
  assign done     = slv_ack || tmo_fire;

  // Slave side: mirrors the owner during BUSY, all zero when idle.
  assign o_s_wb_adr = own_req.adr;
  assign o_s_wb_dat = own_req.dat;
  assign o_s_wb_sel = own_req.sel;
  assign o_s_wb_we  = own_req.we;
  assign o_s_wb_stb = busy;
  assign o_s_wb_cyc = busy;

  // Master side: ack only to the owner; read data broadcast, except the
  // owner sees the fixed pattern on a forced termination.
  assign rdt_bus     = busy ? i_s_wb_rdt : '0;
  assign o_m0_wb_ack = done && (grant_q == GNT_M0);
  assign o_m1_wb_ack = done && (grant_q == GNT_M1);
  assign o_m0_wb_rdt = (tmo_fire && grant_q == GNT_M0) ? TIMEOUT_RDT : rdt_bus;
  assign o_m1_wb_rdt = (tmo_fire && grant_q == GNT_M1) ? TIMEOUT_RDT : rdt_bus;

  assign o_grant   = grant_q;
  assign o_timeout = tmo_fire;

  // Next-state logic: round-robin pick in IDLE, release on ack/abort/timeout.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (i_m0_wb_stb && (!i_m1_wb_stb || last_q)) begin
          state_d = ST_BUSY;
          grant_d = GNT_M0;
          last_d  = 1'b0;
        end else if (i_m1_wb_stb) begin
          state_d = ST_BUSY;
          grant_d = GNT_M1;
          last_d  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (done || abort) begin
          state_d = ST_IDLE;
          grant_d = GNT_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  // State, grant and round-robin pointer; m1 as last owner lets the CPU win first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_NONE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
